main_decode_pipe: RTL and testbench

- Next-generation MIPS main decoder: decodes {op, funct} in ID and drives the ID/EX pipeline register.
- Generates the 8-bit control bundle, an ALU op, and extended controls (bne, jal, jr, mult/div).
- Owns load-use hazard detection and a multi-cycle mult/div busy tracker, and produces the ID stall.
- Sits between the IF/ID register and the execute stage.

---
 rtl/main_decode_pipe_pkg.sv | 112 +++++++++++
 rtl/main_decode_pipe_if.sv | 31 +++
 rtl/main_decode_pipe_md_busy_tracker.sv | 56 +++++
 rtl/main_decode_pipe.sv | 120 ++++++++++++
 tb/tb_main_decode_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/main_decode_pipe_pkg.sv
// Shared decode constants for the MIPS main decoder: opcodes, functs, ALU op codes,
// control-bundle bit positions and the decoder function used in the ID stage.
package main_decode_pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;

    localparam int SIG_JUMP     = 7;
    localparam int SIG_REGWRITE = 6;
    localparam int SIG_REGDST   = 5;
    localparam int SIG_ALUSRC   = 4;
    localparam int SIG_BRANCH   = 3;
    localparam int SIG_MEMWRITE = 2;
    localparam int SIG_MEMTOREG = 1;
    localparam int SIG_MEMEN    = 0;

    localparam int EXT_BNE     = 3;
    localparam int EXT_JAL     = 2;
    localparam int EXT_JR      = 1;
    localparam int EXT_ILLEGAL = 0;

    typedef enum logic [3:0] {
        ALU_NOP   = 4'd0,
        ALU_ADD   = 4'd1,
        ALU_SUB   = 4'd2,
        ALU_AND   = 4'd3,
        ALU_OR    = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_LUI   = 4'd6,
        ALU_RTYPE = 4'd7
    } aluop_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [7:0] sigs;
        logic [3:0] ext;
        aluop_e     aluop;
        logic       reads_rt;
        logic       md_class;
        logic       md_issue;
        logic       md_div;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d = '0;
        case (instr[31:26])
            OP_ADDI: begin d.sigs = 8'b0101_0000; d.aluop = ALU_ADD; end
            OP_ANDI: begin d.sigs = 8'b0101_0000; d.aluop = ALU_AND; end
            OP_ORI:  begin d.sigs = 8'b0101_0000; d.aluop = ALU_OR;  end
            OP_XORI: begin d.sigs = 8'b0101_0000; d.aluop = ALU_XOR; end
            OP_LUI:  begin d.sigs = 8'b0101_0000; d.aluop = ALU_LUI; end
            OP_RTYPE: begin
                d.reads_rt = 1'b1;
                case (instr[5:0])
                    FN_JR: begin
                        d.sigs         = 8'b1000_0000;
                        d.ext[EXT_JR]  = 1'b1;
                    end
                    FN_MULT, FN_DIV: begin
                        d.md_class = 1'b1;
                        d.md_issue = 1'b1;
                        d.md_div   = (instr[5:0] == FN_DIV);
                    end
                    FN_MFHI, FN_MFLO: begin
                        d.sigs     = 8'b0110_0000;
                        d.aluop    = ALU_RTYPE;
                        d.md_class = 1'b1;
                    end
                    default: begin
                        d.sigs  = 8'b0110_0000;
                        d.aluop = ALU_RTYPE;
                    end
                endcase
            end
            OP_J:   d.sigs = 8'b1000_0000;
            OP_JAL: begin d.sigs = 8'b1100_0000; d.ext[EXT_JAL] = 1'b1; end
            OP_BEQ: begin d.sigs = 8'b0000_1000; d.aluop = ALU_SUB; d.reads_rt = 1'b1; end
            OP_BNE: begin
                d.sigs         = 8'b0000_1000;
                d.aluop        = ALU_SUB;
                d.reads_rt     = 1'b1;
                d.ext[EXT_BNE] = 1'b1;
            end
            OP_LW:  begin d.sigs = 8'b0101_0011; d.aluop = ALU_ADD; end
            OP_SW:  begin d.sigs = 8'b0001_0101; d.aluop = ALU_ADD; d.reads_rt = 1'b1; end
            default: d.ext[EXT_ILLEGAL] = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/main_decode_pipe_if.sv
// ID-stage handshake and ID/EX register bundle between the pipeline control and the decoder.
interface main_decode_pipe_if #(
    parameter int ALUOP_W = 4
);
    logic               id_valid;
    logic [31:0]        id_instr;
    logic               ex_stall;
    logic               flush;
    logic               id_stall;
    logic               ex_valid;
    logic [7:0]         ex_sigs;
    logic [3:0]         ex_ext;
    logic [ALUOP_W-1:0] ex_aluop;
    logic [4:0]         ex_rs;
    logic [4:0]         ex_rt;
    logic [4:0]         ex_rd;
    logic               md_start;
    logic               md_busy;

    modport master (
        output id_valid, id_instr, ex_stall, flush,
        input  id_stall, ex_valid, ex_sigs, ex_ext, ex_aluop, ex_rs, ex_rt, ex_rd,
               md_start, md_busy
    );

    modport slave (
        input  id_valid, id_instr, ex_stall, flush,
        output id_stall, ex_valid, ex_sigs, ex_ext, ex_aluop, ex_rs, ex_rt, ex_rd,
               md_start, md_busy
    );
endinterface

// File: rtl/main_decode_pipe_md_busy_tracker.sv
// Tracks occupancy of the multi-cycle mult/div unit: IDLE/BUSY FSM with a down-counter.
module md_busy_tracker
    import main_decode_pipe_pkg::*;
#(
    parameter int MULT_LATENCY = 4,
    parameter int DIV_LATENCY  = 32,
    parameter int CNT_W        = 6
) (
    input  logic clk,
    input  logic resetn,
    input  logic md_start_i,
    input  logic md_div_i,
    output logic md_busy_o
);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LATENCY - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter holds the remaining busy cycles after the current one; zero means last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = md_div_i ? DIV_CNT : MULT_CNT;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        md_busy_o = (state_q == MD_BUSY);
    end
endmodule

// File: rtl/main_decode_pipe.sv
// MIPS ID-stage main decoder: decodes the instruction, detects load-use and mult/div
// hazards, produces the ID stall and drives the ID/EX pipeline register.
module main_decode_pipe
    import main_decode_pipe_pkg::*;
#(
    parameter int MULT_LATENCY = 4,
    parameter int DIV_LATENCY  = 32,
    parameter int CNT_W        = 6,
    parameter int ALUOP_W      = 4
) (
    input logic               clk,
    input logic               resetn,
    main_decode_pipe_if.slave pipe
);
    dec_t               dec;
    logic [4:0]         id_rs, id_rt, id_rd;
    logic               hz, mdz, accept, id_stall, md_start, md_busy;
    logic               ex_valid_q, ex_valid_d;
    logic [7:0]         sigs_q, sigs_d;
    logic [3:0]         ext_q, ext_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic [4:0]         rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;

    always_comb begin
        dec   = decode(pipe.id_instr);
        id_rs = pipe.id_instr[25:21];
        id_rt = pipe.id_instr[20:16];
        id_rd = dec.ext[EXT_JAL] ? 5'd31 : pipe.id_instr[15:11];
    end

    always_comb begin
        hz  = ex_valid_q & sigs_q[SIG_MEMTOREG] & (rt_q != '0)
            & ((rt_q == id_rs) | (dec.reads_rt & (rt_q == id_rt)));
        mdz = md_busy & dec.md_class;
    end

    // Flush beats the execute-stage stall, which beats hazard bubbles.
    always_comb begin
        ex_valid_d = ex_valid_q;
        sigs_d     = sigs_q;
        ext_d      = ext_q;
        aluop_d    = aluop_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        id_stall   = 1'b0;
        accept     = 1'b0;
        if (pipe.flush || (!pipe.ex_stall && pipe.id_valid && (hz || mdz))) begin
            ex_valid_d = 1'b0;
            sigs_d     = '0;
            ext_d      = '0;
            aluop_d    = '0;
            rs_d       = '0;
            rt_d       = '0;
            rd_d       = '0;
            id_stall   = !pipe.flush;
        end else if (pipe.ex_stall) begin
            id_stall = 1'b1;
        end else begin
            ex_valid_d = pipe.id_valid;
            sigs_d     = dec.sigs;
            ext_d      = dec.ext;
            aluop_d    = ALUOP_W'(dec.aluop);
            rs_d       = id_rs;
            rt_d       = id_rt;
            rd_d       = id_rd;
            accept     = pipe.id_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_valid_q <= 1'b0;
            sigs_q     <= '0;
            ext_q      <= '0;
            aluop_q    <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            sigs_q     <= sigs_d;
            ext_q      <= ext_d;
            aluop_q    <= aluop_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
        end
    end

    // md_start is combinational, so it is held low while reset is asserted.
    always_comb begin
        md_start = resetn & accept & dec.md_issue;
    end

    md_busy_tracker #(
        .MULT_LATENCY (MULT_LATENCY),
        .DIV_LATENCY  (DIV_LATENCY),
        .CNT_W        (CNT_W)
    ) u_md_busy_tracker (
        .clk        (clk),
        .resetn     (resetn),
        .md_start_i (md_start),
        .md_div_i   (dec.md_div),
        .md_busy_o  (md_busy)
    );

    always_comb begin
        pipe.id_stall = id_stall;
        pipe.ex_valid = ex_valid_q;
        pipe.ex_sigs  = sigs_q;
        pipe.ex_ext   = ext_q;
        pipe.ex_aluop = aluop_q;
        pipe.ex_rs    = rs_q;
        pipe.ex_rt    = rt_q;
        pipe.ex_rd    = rd_q;
        pipe.md_start = md_start;
        pipe.md_busy  = md_busy;
    end
endmodule

// File: tb/tb_main_decode_pipe.sv
// Directed self-checking bench for main_decode_pipe with hand-computed expected values.
module tb_main_decode_pipe;

    localparam logic [31:0] I_LW    = 32'h8C22_0004;
    localparam logic [31:0] I_ADD   = 32'h0044_1820;
    localparam logic [31:0] I_ORI   = 32'h3405_0001;
    localparam logic [31:0] I_BEQ   = 32'h1022_0004;
    localparam logic [31:0] I_BNE   = 32'h1422_0004;
    localparam logic [31:0] I_DIV   = 32'h00C7_001A;
    localparam logic [31:0] I_MULT  = 32'h00C7_0018;
    localparam logic [31:0] I_MFLO  = 32'h0000_4012;
    localparam logic [31:0] I_ADDI  = 32'h2009_0005;
    localparam logic [31:0] I_JAL   = 32'h0C00_0010;
    localparam logic [31:0] I_JR    = 32'h03E0_0008;
    localparam logic [31:0] I_SW    = 32'hAC22_0000;
    localparam logic [31:0] I_BAD   = 32'hFC00_0000;

    logic clk;
    logic resetn;
    int   nCompared;
    int   nMismatched;

    main_decode_pipe_if #(.ALUOP_W(4)) pipe ();

    main_decode_pipe #(
        .MULT_LATENCY (4),
        .DIV_LATENCY  (32),
        .CNT_W        (6),
        .ALUOP_W      (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .pipe   (pipe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic fl);
        pipe.id_valid = v;
        pipe.id_instr = ins;
        pipe.ex_stall = st;
        pipe.flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        drive(1'b1, I_DIV, 1'b0, 1'b0);
        #1;
        nCompared++;
        if (pipe.md_start !== 1'b1) begin nMismatched++; $display("[TB] FAIL pre_reset_md_start: got %b want 1", pipe.md_start); end
        tick();
        drive(1'b1, I_LW, 1'b0, 1'b0);
        nCompared++;
        if (pipe.md_busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL pre_reset_md_busy: got %b want 1", pipe.md_busy); end
        tick();
        nCompared++;
        if (pipe.ex_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL pre_reset_ex_valid: got %b want 1", pipe.ex_valid); end
        drive(1'b1, I_DIV, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        nCompared++;
        if (pipe.ex_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ex_valid: got %b want 0", pipe.ex_valid); end
        nCompared++;
        if (pipe.ex_sigs !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_ex_sigs: got %b want 00000000", pipe.ex_sigs); end
        nCompared++;
        if (pipe.ex_ext !== 4'h0) begin nMismatched++; $display("[TB] FAIL reset_ex_ext: got %b want 0000", pipe.ex_ext); end
        nCompared++;
        if (pipe.ex_aluop !== 4'h0) begin nMismatched++; $display("[TB] FAIL reset_ex_aluop: got %0d want 0", pipe.ex_aluop); end
        nCompared++;
        if ({pipe.ex_rs, pipe.ex_rt, pipe.ex_rd} !== 15'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_regs: got rs=%0d rt=%0d rd=%0d want 0", pipe.ex_rs, pipe.ex_rt, pipe.ex_rd);
        end
        nCompared++;
        if (pipe.md_busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_md_busy: got %b want 0", pipe.md_busy); end
        nCompared++;
        if (pipe.md_start !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_md_start: got %b want 0", pipe.md_start); end
        tick();
        resetn = 1'b1;
        drive(1'b1, I_LW, 1'b0, 1'b0);
        tick();
        nCompared++;
        if (pipe.ex_sigs !== 8'b0101_0011) begin nMismatched++; $display("[TB] FAIL lw_sigs: got %b want 01010011", pipe.ex_sigs); end
        nCompared++;
        if (pipe.ex_rt !== 5'd2) begin nMismatched++; $display("[TB] FAIL lw_rt: got %0d want 2", pipe.ex_rt); end
        nCompared++;
        if (pipe.ex_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL lw_valid: got %b want 1", pipe.ex_valid); end
        nCompared++;
        if (pipe.ex_aluop !== 4'd1) begin nMismatched++; $display("[TB] FAIL lw_aluop: got %0d want 1", pipe.ex_aluop); end
        nCompared++;
        if (pipe.md_busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL post_reset_md_busy: got %b want 0", pipe.md_busy); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_load_use();
        drive(1'b1, I_LW, 1'b0, 1'b0);
        tick();
        drive(1'b1, I_ADD, 1'b0, 1'b0);
        #1;
        nCompared++;
        if (pipe.id_stall !== 1'b1) begin nMismatched++; $display("[TB] FAIL lu_stall: got %b want 1", pipe.id_stall); end
        tick();
        nCompared++;
        if (pipe.ex_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL lu_bubble: got %b want 0", pipe.ex_valid); end
        nCompared++;
        if (pipe.id_stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL lu_release: got %b want 0", pipe.id_stall); end
        tick();
        nCompared++;
        if (pipe.ex_valid !== 1'b1 || pipe.ex_sigs !== 8'b0110_0000) begin
            nMismatched++;
            $display("[TB] FAIL lu_add: got valid=%b sigs=%b want 1 01100000", pipe.ex_valid, pipe.ex_sigs);
        end
        nCompared++;
        if (pipe.ex_rd !== 5'd3 || pipe.ex_rs !== 5'd2 || pipe.ex_rt !== 5'd4) begin
            nMismatched++;
            $display("[TB] FAIL lu_add_regs: got rs=%0d rt=%0d rd=%0d want 2 4 3", pipe.ex_rs, pipe.ex_rt, pipe.ex_rd);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_flush_priority();
        drive(1'b1, I_LW, 1'b0, 1'b0);
        tick();
        drive(1'b1, I_ADD, 1'b1, 1'b1);
        #1;
        nCompared++;
        if (pipe.id_stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_stall: got %b want 0", pipe.id_stall); end
        tick();
        nCompared++;
        if (pipe.ex_valid !== 1'b0 || pipe.ex_sigs !== 8'h00) begin
            nMismatched++;
            $display("[TB] FAIL flush_bubble: got valid=%b sigs=%b want 0 00000000", pipe.ex_valid, pipe.ex_sigs);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_ex_stall_hold();
        drive(1'b1, I_ORI, 1'b0, 1'b0);
        tick();
        nCompared++;
        if (pipe.ex_sigs !== 8'b0101_0000 || pipe.ex_aluop !== 4'd4) begin
            nMismatched++;
            $display("[TB] FAIL ori_load: got sigs=%b aluop=%0d want 01010000 4", pipe.ex_sigs, pipe.ex_aluop);
        end
        drive(1'b1, I_BEQ, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            nCompared++;
            if (pipe.id_stall !== 1'b1) begin nMismatched++; $display("[TB] FAIL hold_stall%0d: got %b want 1", i, pipe.id_stall); end
            tick();
            nCompared++;
            if (pipe.ex_sigs !== 8'b0101_0000 || pipe.ex_rt !== 5'd5 || pipe.ex_valid !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL hold_sigs%0d: got sigs=%b rt=%0d want 01010000 5", i, pipe.ex_sigs, pipe.ex_rt);
            end
        end
        drive(1'b1, I_BEQ, 1'b0, 1'b0);
        #1;
        nCompared++;
        if (pipe.id_stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL hold_release: got %b want 0", pipe.id_stall); end
        tick();
        nCompared++;
        if (pipe.ex_sigs !== 8'b0000_1000 || pipe.ex_aluop !== 4'd2) begin
            nMismatched++;
            $display("[TB] FAIL beq_load: got sigs=%b aluop=%0d want 00001000 2", pipe.ex_sigs, pipe.ex_aluop);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_div_busy();
        int busyCycles;
        int mfloCycle;
        busyCycles = 0;
        mfloCycle  = -1;
        drive(1'b1, I_DIV, 1'b0, 1'b0);
        #1;
        nCompared++;
        if (pipe.md_start !== 1'b1) begin nMismatched++; $display("[TB] FAIL div_start: got %b want 1", pipe.md_start); end
        tick();
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) drive(1'b1, I_ADDI, 1'b0, 1'b0);
            else if (c >= 5 && mfloCycle < 0) drive(1'b1, I_MFLO, 1'b0, 1'b0);
            else drive(1'b0, 32'h0, 1'b0, 1'b0);
            #1;
            if (pipe.md_busy === 1'b1) busyCycles++;
            nCompared++;
            if (pipe.md_start !== 1'b0) begin nMismatched++; $display("[TB] FAIL div_start_pulse c%0d: got %b want 0", c, pipe.md_start); end
            if (c == 1) begin
                nCompared++;
                if (pipe.id_stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL addi_nostall: got %b want 0", pipe.id_stall); end
            end
            if (c >= 5 && mfloCycle < 0) begin
                nCompared++;
                if (pipe.id_stall !== (c <= 32)) begin
                    nMismatched++;
                    $display("[TB] FAIL mflo_stall c%0d: got %b want %b", c, pipe.id_stall, (c <= 32));
                end
                if (pipe.id_stall === 1'b0) mfloCycle = c;
            end
            tick();
            if (c == 1) begin
                nCompared++;
                if (pipe.ex_sigs !== 8'b0101_0000 || pipe.ex_valid !== 1'b1) begin
                    nMismatched++;
                    $display("[TB] FAIL addi_load: got valid=%b sigs=%b want 1 01010000", pipe.ex_valid, pipe.ex_sigs);
                end
            end
            if (mfloCycle == c) begin
                nCompared++;
                if (pipe.ex_sigs !== 8'b0110_0000 || pipe.ex_valid !== 1'b1) begin
                    nMismatched++;
                    $display("[TB] FAIL mflo_load: got valid=%b sigs=%b want 1 01100000", pipe.ex_valid, pipe.ex_sigs);
                end
            end
        end
        nCompared++;
        if (busyCycles != 32) begin nMismatched++; $display("[TB] FAIL div_busy_len: got %0d want 32", busyCycles); end
        nCompared++;
        if (mfloCycle != 33) begin nMismatched++; $display("[TB] FAIL mflo_issue_cycle: got %0d want 33", mfloCycle); end
    endtask

    task automatic test_back_to_back();
        int accCycle;
        accCycle = -1;
        drive(1'b1, I_MULT, 1'b0, 1'b0);
        #1;
        nCompared++;
        if (pipe.md_start !== 1'b1) begin nMismatched++; $display("[TB] FAIL mult_start: got %b want 1", pipe.md_start); end
        tick();
        for (int c = 1; c <= 10; c++) begin
            if (accCycle < 0) drive(1'b1, I_MULT, 1'b0, 1'b0);
            else drive(1'b0, 32'h0, 1'b0, 1'b0);
            #1;
            nCompared++;
            if (pipe.md_start !== (c == 5)) begin
                nMismatched++;
                $display("[TB] FAIL mult2_start c%0d: got %b want %b", c, pipe.md_start, (c == 5));
            end
            if (accCycle < 0) begin
                nCompared++;
                if (pipe.id_stall !== (c <= 4)) begin
                    nMismatched++;
                    $display("[TB] FAIL mult2_stall c%0d: got %b want %b", c, pipe.id_stall, (c <= 4));
                end
                if (pipe.id_stall === 1'b0) accCycle = c;
            end
            tick();
        end
        nCompared++;
        if (accCycle != 5) begin nMismatched++; $display("[TB] FAIL mult2_issue_cycle: got %0d want 5", accCycle); end
        nCompared++;
        if (pipe.md_busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL mult2_done: got %b want 0", pipe.md_busy); end
    endtask

    task automatic test_ext_ops();
        drive(1'b1, I_JAL, 1'b0, 1'b0);
        tick();
        nCompared++;
        if (pipe.ex_sigs !== 8'b1100_0000 || pipe.ex_ext !== 4'b0100 || pipe.ex_rd !== 5'd31) begin
            nMismatched++;
            $display("[TB] FAIL jal: got sigs=%b ext=%b rd=%0d want 11000000 0100 31", pipe.ex_sigs, pipe.ex_ext, pipe.ex_rd);
        end
        drive(1'b1, I_BNE, 1'b0, 1'b0);
        tick();
        nCompared++;
        if (pipe.ex_sigs !== 8'b0000_1000 || pipe.ex_ext !== 4'b1000) begin
            nMismatched++;
            $display("[TB] FAIL bne: got sigs=%b ext=%b want 00001000 1000", pipe.ex_sigs, pipe.ex_ext);
        end
        drive(1'b1, I_BAD, 1'b0, 1'b0);
        tick();
        nCompared++;
        if (pipe.ex_sigs !== 8'h00 || pipe.ex_ext !== 4'b0001) begin
            nMismatched++;
            $display("[TB] FAIL illegal: got sigs=%b ext=%b want 00000000 0001", pipe.ex_sigs, pipe.ex_ext);
        end
        drive(1'b1, I_JR, 1'b0, 1'b0);
        tick();
        nCompared++;
        if (pipe.ex_sigs !== 8'b1000_0000 || pipe.ex_ext !== 4'b0010) begin
            nMismatched++;
            $display("[TB] FAIL jr: got sigs=%b ext=%b want 10000000 0010", pipe.ex_sigs, pipe.ex_ext);
        end
        drive(1'b1, I_SW, 1'b0, 1'b0);
        tick();
        nCompared++;
        if (pipe.ex_sigs !== 8'b0001_0101 || pipe.ex_ext !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL sw: got sigs=%b ext=%b want 00010101 0000", pipe.ex_sigs, pipe.ex_ext);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        resetn      = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_load_use();
        test_flush_priority();
        test_ex_stall_hold();
        test_div_busy();
        test_back_to_back();
        test_ext_ops();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
